uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Parametrised UART receiver that oversamples a serial line, assembles bytes into multi-byte words, and buffers completed words in a small FIFO.
- The FIFO is read through a valid/ready interface.
- Successor to the fixed 32-bit/8-bit word receive path. Adds:
  - configurable word, byte and FIFO geometry;
  - framing-error and overrun reporting;
  - an inter-byte timeout that flushes partial words.
- Sits between the board RX pin and the core-side word consumer.

Parameters:
- WORD_WIDTH, 32: output word width in bits. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: data bits per UART frame (5–9).
- FIFO_DEPTH, 4: number of word entries. Any value ≥ 1; need not be a power of two.
- CLK_FREQ, 200_000_000: clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- OVERSAMPLE, 16: ticks per bit. Even, ≥ 8.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes of one word before the partial word is discarded.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- sig_in, in, 1: serial RX line; idles high.
- word_data, out, WORD_WIDTH: head-of-FIFO word.
- word_valid, out, 1: FIFO not empty.
- word_ready, in, 1: consumer accepts word_data this cycle.
- fifo_count, out, $clog2(FIFO_DEPTH+1): occupied entries.
- rx_busy, out, 1: high while not in IDLE, or while a partial word is held.
- frame_err, out, 1: one-cycle pulse on a bad stop bit.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.
- timeout, out, 1: one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset (reset = 0, asynchronous): every output is 0; the FIFO is empty; the FSM is in WAIT_IDLE; the byte counter and assembly register are 0.
- Input sync: sig_in passes through a 2-flop synchronizer. All line timing is measured on the synchronized signal (2-cycle latency).
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), computed at elaboration (109 for the defaults).
  - The counter runs freely and emits a one-cycle tick every DIV clocks.
- FSM states: WAIT_IDLE, IDLE, START, DATA, STOP.
  - WAIT_IDLE: entered from reset. Stays until the line has been high for OVERSAMPLE consecutive ticks, then goes to IDLE. This prevents false starts when reset is released mid-frame.
  - IDLE: a synchronized falling edge moves to START and clears the tick phase counter.
  - START: at tick OVERSAMPLE/2 (mid-bit), the line is sampled:
    - low: go to DATA with bit index 0;
    - high: glitch; return to IDLE with no flags.
  - DATA: one sample every OVERSAMPLE ticks at mid-bit. Data is LSB first and shifts into the byte register. After BYTE_WIDTH samples, go to STOP.
  - STOP: sample at mid-bit.
    - High: byte accepted. It is written into word lane [byte_cnt*BYTE_WIDTH +: BYTE_WIDTH]; the first received byte lands in the LSB lane. byte_cnt increments. Go to IDLE.
    - Low: frame_err pulses; the byte and the whole partial word are discarded; byte_cnt = 0. Go to WAIT_IDLE.
- Word completion:
  - When byte_cnt reaches WORD_WIDTH/BYTE_WIDTH, the word is pushed in the cycle after the stop sample, and byte_cnt returns to 0.
  - word_valid rises the cycle after the push. The FIFO is registered; there is no fall-through.
- FIFO rules:
  - A pop occurs when word_valid && word_ready.
  - Push while full with no pop in the same cycle: the word is dropped, overrun pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur; no overrun; fifo_count is unchanged.
  - Push and pop in the same cycle while non-full and non-empty: fifo_count is unchanged.
  - Read and write pointers wrap at FIFO_DEPTH (not at a power of two).
  - word_data is stable while word_valid && !word_ready.
- Timeout:
  - While in IDLE with byte_cnt ≠ 0, a bit-time counter increments every OVERSAMPLE ticks.
  - On reaching TIMEOUT_BITS: timeout pulses and byte_cnt is cleared.
  - A start-bit edge clears the counter.
- Simultaneous events: a timeout and a falling edge in the same cycle: the edge wins and no timeout is flagged.

Optional Feature:
- Macro: UART_WORD_RX_PARITY_EN.
- When defined:
  - a PARITY state is inserted between DATA and STOP, sampling one even-parity bit;
  - an extra output port parity_err (out, 1) pulses one cycle on mismatch;
  - a mismatching byte and its partial word are discarded exactly as for a framing error, and the FSM then continues through STOP normally.
- When undefined: no parity bit, no parity_err port; the frame is start + BYTE_WIDTH data bits + stop.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum rx_state_t;
  - a function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE;
  - the localparam helper BYTES_PER_WORD.
- Natural sub-module: uart_rx_byte. It contains the synchronizer, tick generator and bit FSM, and outputs byte_data, byte_valid and frame_err. Word assembly, timeout and the FIFO stay in uart_word_rx.

Test Plan:
- Send bytes 0x03, 0x04, 0xAA, 0xFF (8680 ns/bit, defaults) with word_ready = 1 → one word 0xFFAA0403; word_valid for 1 cycle; fifo_count returns to 0.
- Send 5 words with word_ready = 0 → fifo_count = 4; overrun pulses exactly once after the 5th word's last stop bit; popping yields words 1–4 in order.
- Send byte 0x55 with stop bit forced low → frame_err pulses once; the next 4 valid bytes 0xBB, 0xCC, 0xDD, 0xEE form word 0xEEDDCCBB.
- Send 2 bytes, then leave the line idle 25 bit-times → timeout pulses at bit-time 20; the next 4 bytes form a clean word with no stale lanes.
- Drive a 2 µs low glitch on an idle line → no byte and no flags; state returns to IDLE.
- Assert reset mid-byte 3, release while the line is low → all outputs 0; no word is emitted until the line has been high for 1 bit-time; the following 4-byte word is correct.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and elaboration helpers for the word receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } rx_state_t;

    // Rounded-to-nearest clock divider for one oversample tick.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        return int'((clk_freq + (baud * oversample) / 2) / (baud * oversample));
    endfunction

    function automatic int bytes_per_word(input int word_width, input int byte_width);
        return word_width / byte_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : Synchronizer, oversample tick generator and bit-level FSM.
//               Optional even parity bit with UART_WORD_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BYTE_WIDTH = 8,
    parameter int CLK_FREQ   = 200_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sig_in,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    output logic                  frame_err,
`ifdef UART_WORD_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  busy,
    output logic                  tick,
    output logic                  in_idle,
    output logic                  start_edge
);

    localparam int DIV     = calc_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OVERSAMPLE));
    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_PH_W  = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(BYTE_WIDTH);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PH_MID   = c_PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(BYTE_WIDTH - 1);

    logic [1:0]            r_sync;
    logic                  r_line_d;
    logic [c_DIV_W-1:0]    r_div_cnt;
    rx_state_t             r_state, w_state_next;
    logic [c_PH_W-1:0]     r_phase, w_phase_next;
    logic [c_BIT_W-1:0]    r_bit_idx, w_bit_next;
    logic [BYTE_WIDTH-1:0] r_shift, w_shift_next;
    logic                  r_bad, w_bad_next;
    logic                  w_byte_done, w_frame_bad;
    logic [BYTE_WIDTH-1:0] r_byte_data;
    logic                  r_byte_valid, r_frame_err, r_busy;
`ifdef UART_WORD_RX_PARITY_EN
    logic                  w_par_bad, r_parity_err;
`endif

    logic w_line, w_fall, w_tick;
    assign w_line = r_sync[1];
    assign w_fall = r_line_d & ~w_line;
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_bad_next   = r_bad;
        w_byte_done  = 1'b0;
        w_frame_bad  = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
        w_par_bad    = 1'b0;
`endif
        case (r_state)
            // Require a full bit-time of idle line before trusting edges.
            WAIT_IDLE: begin
                if (!w_line) begin
                    w_phase_next = '0;
                end else if (w_tick) begin
                    if (r_phase == c_PH_LAST) begin
                        w_phase_next = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_phase_next = r_phase + c_PH_W'(1);
                    end
                end
            end
            IDLE: begin
                if (w_fall) begin
                    w_phase_next = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_phase == c_PH_MID) begin
                        w_phase_next = '0;
                        if (w_line) begin
                            w_state_next = IDLE;
                        end else begin
                            w_state_next = DATA;
                            w_bit_next   = '0;
                            w_bad_next   = 1'b0;
                        end
                    end else begin
                        w_phase_next = r_phase + c_PH_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_phase == c_PH_LAST) begin
                        w_phase_next = '0;
                        w_shift_next = {w_line, r_shift[BYTE_WIDTH-1:1]};
                        if (r_bit_idx == c_BIT_LAST) begin
`ifdef UART_WORD_RX_PARITY_EN
                            w_state_next = PARITY;
`else
                            w_state_next = STOP;
`endif
                        end else begin
                            w_bit_next = r_bit_idx + c_BIT_W'(1);
                        end
                    end else begin
                        w_phase_next = r_phase + c_PH_W'(1);
                    end
                end
            end
`ifdef UART_WORD_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (r_phase == c_PH_LAST) begin
                        w_phase_next = '0;
                        w_state_next = STOP;
                        if (w_line != ^r_shift) begin
                            w_par_bad  = 1'b1;
                            w_bad_next = 1'b1;
                        end
                    end else begin
                        w_phase_next = r_phase + c_PH_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_phase == c_PH_LAST) begin
                        w_phase_next = '0;
                        if (w_line) begin
                            w_byte_done  = !r_bad;
                            w_state_next = IDLE;
                        end else begin
                            w_frame_bad  = 1'b1;
                            w_state_next = WAIT_IDLE;
                        end
                    end else begin
                        w_phase_next = r_phase + c_PH_W'(1);
                    end
                end
            end
            default: w_state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync       <= 2'b11;
            r_line_d     <= 1'b1;
            r_div_cnt    <= '0;
            r_state      <= WAIT_IDLE;
            r_phase      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_bad        <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync       <= {r_sync[0], sig_in};
            r_line_d     <= w_line;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_bit_idx    <= w_bit_next;
            r_shift      <= w_shift_next;
            r_bad        <= w_bad_next;
            r_byte_valid <= w_byte_done;
            r_frame_err  <= w_frame_bad;
            r_busy       <= (w_state_next != IDLE);
            if (w_byte_done) begin
                r_byte_data <= r_shift;
            end
`ifdef UART_WORD_RX_PARITY_EN
            r_parity_err <= w_par_bad;
`endif
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;
`ifdef UART_WORD_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif
    assign busy       = r_busy;
    assign tick       = w_tick;
    assign in_idle    = (r_state == IDLE);
    assign start_edge = (r_state == IDLE) && w_fall;

endmodule
`default_nettype wire

// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_rx
// Description : UART word receiver: byte assembly, inter-byte timeout and a
//               registered word FIFO. Parity option: UART_WORD_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLK_FREQ     = 200_000_000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            sig_in,
    output logic [WORD_WIDTH-1:0]           word_data,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            rx_busy,
    output logic                            frame_err,
    output logic                            overrun,
`ifdef UART_WORD_RX_PARITY_EN
    output logic                            parity_err,
`endif
    output logic                            timeout
);

    localparam int BYTES_PER_WORD = bytes_per_word(WORD_WIDTH, BYTE_WIDTH);
    localparam int c_BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_PH_W   = $clog2(OVERSAMPLE);
    localparam int c_TO_W   = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PH_W-1:0]   c_PH_LAST   = c_PH_W'(OVERSAMPLE - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_BITS - 1);

    logic [BYTE_WIDTH-1:0] w_byte_data;
    logic w_byte_valid, w_frame_err, w_busy, w_tick, w_in_idle, w_start_edge, w_discard;
`ifdef UART_WORD_RX_PARITY_EN
    logic w_parity_err;
`endif

    uart_rx_byte #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx_byte (
        .clock      (clock),
        .reset      (reset),
        .sig_in     (sig_in),
        .byte_data  (w_byte_data),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err),
`ifdef UART_WORD_RX_PARITY_EN
        .parity_err (w_parity_err),
`endif
        .busy       (w_busy),
        .tick       (w_tick),
        .in_idle    (w_in_idle),
        .start_edge (w_start_edge)
    );

`ifdef UART_WORD_RX_PARITY_EN
    assign w_discard = w_frame_err | w_parity_err;
`else
    assign w_discard = w_frame_err;
`endif

    logic [c_BCNT_W-1:0]   r_byte_cnt;
    logic [WORD_WIDTH-1:0] r_word, w_word_next;
    logic [c_PH_W-1:0]     r_to_phase;
    logic [c_TO_W-1:0]     r_to_bits;
    logic                  r_timeout, r_overrun, w_to_fire;
    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_last_byte, w_push_req, w_full, w_pop, w_push;

    // The word pushed includes the byte arriving this cycle.
    always_comb begin
        w_word_next = r_word;
        w_word_next[int'(r_byte_cnt) * BYTE_WIDTH +: BYTE_WIDTH] = w_byte_data;
        w_last_byte = (r_byte_cnt == c_BCNT_LAST);
        w_push_req  = w_byte_valid && w_last_byte;
        w_full      = (r_count == c_CNT_FULL);
        w_pop       = (r_count != '0) && word_ready;
        w_push      = w_push_req && (!w_full || w_pop);
        w_to_fire   = !w_start_edge && (r_byte_cnt != '0) && w_in_idle && w_tick &&
                      (r_to_phase == c_PH_LAST) && (r_to_bits == c_TO_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (w_discard || w_to_fire || (w_byte_valid && w_last_byte)) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (w_byte_valid) begin
            r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
            r_word     <= w_word_next;
        end
    end

    // A start edge restarts the idle measurement, so it beats a same-cycle timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_to_phase <= '0;
            r_to_bits  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (w_start_edge || r_byte_cnt == '0) begin
                r_to_phase <= '0;
                r_to_bits  <= '0;
            end else if (w_in_idle && w_tick) begin
                if (r_to_phase == c_PH_LAST) begin
                    r_to_phase <= '0;
                    r_to_bits  <= (r_to_bits == c_TO_LAST) ? '0 : r_to_bits + c_TO_W'(1);
                end else begin
                    r_to_phase <= r_to_phase + c_PH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push_req && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word_next;
                r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    assign word_data  = r_mem[r_rd_ptr];
    assign word_valid = (r_count != '0);
    assign fifo_count = r_count;
    assign rx_busy    = w_busy | (r_byte_cnt != '0);
    assign frame_err  = w_frame_err;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;
`ifdef UART_WORD_RX_PARITY_EN
    assign parity_err = w_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_rx
// Description : Scoreboard bench for uart_word_rx (16 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int BIT_CLKS = 16;

    logic        clock, reset, sig_in, word_ready;
    logic [31:0] word_data;
    logic        word_valid, rx_busy, frame_err, overrun, timeout;
    logic [2:0]  fifo_count;
`ifdef UART_WORD_RX_PARITY_EN
    logic        parity_err;
`endif

    uart_word_rx #(
        .WORD_WIDTH   (32),
        .BYTE_WIDTH   (8),
        .FIFO_DEPTH   (4),
        .CLK_FREQ     (16_000_000),
        .BAUD         (1_000_000),
        .OVERSAMPLE   (8),
        .TIMEOUT_BITS (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sig_in     (sig_in),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_count (fifo_count),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_WORD_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cyc = 0, frame_cnt = 0, overrun_cnt = 0, timeout_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] t2_words [5] = '{32'h01020304, 32'h11223344, 32'hA5A55A5A,
                                  32'hDEADBEEF, 32'hCAFEF00D};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and counts pulses.
    always @(negedge clock) begin
        #1;
        if (reset) begin
            if (word_valid)  valid_cyc++;
            if (frame_err)   frame_cnt++;
            if (overrun)     overrun_cnt++;
            if (timeout)     timeout_cnt++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", word_data);
                end else begin
                    check("word", {32'h0, word_data}, {32'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        sig_in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap_bits);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
`ifdef UART_WORD_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
        sig_in = 1'b1;
        repeat (gap_bits * BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_rx_busy"},    rx_busy, 0);
        check({tag, "_frame_err"},  frame_err, 0);
        check({tag, "_overrun"},    overrun, 0);
        check({tag, "_timeout"},    timeout, 0);
        check({tag, "_word_data"},  word_data, 0);
    endtask

    initial begin
        #10_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int vb, fb, ob, tb0;
        sig_in = 1'b1;
        word_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clock);

        // Single word, consumer always ready.
        vb = valid_cyc;
        exp_q.push_back(32'hFFAA0403);
        send_word(32'hFFAA0403);
        repeat (2 * BIT_CLKS) @(negedge clock);
        check("t1_valid_cycles", valid_cyc - vb, 1);
        check("t1_fifo_count", fifo_count, 0);
        check("t1_rx_busy", rx_busy, 0);
        check("t1_pending", exp_q.size(), 0);

        // Fill the FIFO, then overflow it by one word.
        word_ready = 1'b0;
        ob = overrun_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(t2_words[i]);
            send_word(t2_words[i]);
        end
        repeat (BIT_CLKS) @(negedge clock);
        check("t2_count_full", fifo_count, 4);
        check("t2_no_overrun_yet", overrun_cnt - ob, 0);
        check("t2_head_held", word_data, 32'h01020304);
        send_word(t2_words[4]);
        repeat (BIT_CLKS) @(negedge clock);
        check("t2_overrun_once", overrun_cnt - ob, 1);
        check("t2_count_still_full", fifo_count, 4);
        check("t2_head_after_overrun", word_data, 32'h01020304);
        check("t2_valid", word_valid, 1);
        word_ready = 1'b1;
        wait_drain();
        repeat (2) @(negedge clock);
        check("t2_count_empty", fifo_count, 0);

        // Framing error, then a clean word.
        fb = frame_cnt;
        send_frame(8'h55, 1'b0, 3);
        check("t3_frame_err_once", frame_cnt - fb, 1);
        exp_q.push_back(32'hEEDDCCBB);
        send_word(32'hEEDDCCBB);
        wait_drain();
        check("t3_frame_err_total", frame_cnt - fb, 1);

        // Partial word abandoned by the inter-byte timeout.
        tb0 = timeout_cnt;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        repeat (18 * BIT_CLKS) @(negedge clock);
        check("t4_no_early_timeout", timeout_cnt - tb0, 0);
        check("t4_busy_partial", rx_busy, 1);
        repeat (7 * BIT_CLKS) @(negedge clock);
        check("t4_timeout_once", timeout_cnt - tb0, 1);
        check("t4_busy_cleared", rx_busy, 0);
        exp_q.push_back(32'hD4C3B2A1);
        send_word(32'hD4C3B2A1);
        wait_drain();

        // Short low glitch on an idle line.
        vb = valid_cyc;
        fb = frame_cnt;
        tb0 = timeout_cnt;
        sig_in = 1'b0;
        repeat (3) @(negedge clock);
        sig_in = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clock);
        check("t5_no_word", valid_cyc - vb, 0);
        check("t5_no_frame_err", frame_cnt - fb, 0);
        check("t5_no_timeout", timeout_cnt - tb0, 0);
        check("t5_idle", rx_busy, 0);

        // Reset in the middle of the third byte, released with the line low.
        vb = valid_cyc;
        send_frame(8'h5A, 1'b1, 1);
        send_frame(8'hC3, 1'b1, 1);
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_reset_outputs("t6");
        reset = 1'b1;
        for (int k = 0; k < 5; k++) send_bit(1'b0);
        send_bit(1'b1);
        repeat (2 * BIT_CLKS) @(negedge clock);
        check("t6_no_word", valid_cyc - vb, 0);
        check("t6_fifo_empty", fifo_count, 0);
        exp_q.push_back(32'h87654321);
        send_word(32'h87654321);
        wait_drain();
        repeat (BIT_CLKS) @(negedge clock);
        check("t6_one_word", valid_cyc - vb, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
